// File: rtl/fpu_pkg.sv
// Shared types and constants for the binary32 adder: FSM states, format limits
// and the unpacked-operand record used between pipeline steps.
package fpu_pkg;

  typedef enum logic [3:0] {
    GET_A,
    GET_B,
    UNPACK,
    SPECIAL,
    ALIGN,
    ADD,
    NORM,
    ROUND,
    PACK,
    PUT_Z
  } state_t;

  localparam logic signed [9:0] EXP_BIAS = 10'sd127;
  localparam logic signed [9:0] EXP_MIN  = -10'sd126;
  localparam logic signed [9:0] EXP_MAX  = 10'sd127;
  localparam logic [31:0]       QNAN     = 32'h7FC00000;
  localparam logic [31:0]       POS_INF  = 32'h7F800000;

  // mant: [26] hidden bit, [25:3] fraction, [2] guard, [1] round, [0] sticky
  typedef struct packed {
    logic              sign;
    logic signed [9:0] exp;
    logic [26:0]       mant;
  } operand_t;

  function automatic operand_t unpack_operand(input logic [31:0] f);
    operand_t op;
    op.sign = f[31];
    if (f[30:23] == 8'd0) begin
      op.exp  = EXP_MIN;
      op.mant = {1'b0, f[22:0], 3'b000};
    end else begin
      op.exp  = $signed({2'b00, f[30:23]}) - EXP_BIAS;
      op.mant = {1'b1, f[22:0], 3'b000};
    end
    return op;
  endfunction

endpackage

// File: rtl/fpu_round_pack.sv
// Combinational round-to-nearest-even and binary32 packing of a normalised
// sign/exponent/mantissa(G,R,S). Overflow/inexact ports exist with FPU_ADDER_FLAGS_EN.
module fpu_round_pack
  import fpu_pkg::*;
(
  input  logic              sign_i,
  input  logic signed [9:0] exp_i,
  input  logic [26:0]       mant_i,
  output logic [31:0]       z_o
`ifdef FPU_ADDER_FLAGS_EN
  ,
  output logic              overflow_o,
  output logic              inexact_o
`endif
);

  logic              up;
  logic [24:0]       mant_r;
  logic [23:0]       m;
  logic signed [9:0] exp_r;
  logic              ovf;

  always_comb begin
    up     = mant_i[2] && (mant_i[1] || mant_i[0] || mant_i[3]);
    mant_r = {1'b0, mant_i[26:3]} + {24'd0, up};
    if (mant_r[24]) begin
      m     = mant_r[24:1];
      exp_r = exp_i + 10'sd1;
    end else begin
      m     = mant_r[23:0];
      exp_r = exp_i;
    end
    ovf = exp_r > EXP_MAX;
    if (ovf) begin
      z_o = {sign_i, POS_INF[30:0]};
    end else if (exp_r == EXP_MIN && !m[23]) begin
      z_o = {sign_i, 8'd0, m[22:0]};
    end else begin
      z_o = {sign_i, exp_r[7:0] + 8'd127, m[22:0]};
    end
  end

`ifdef FPU_ADDER_FLAGS_EN
  assign overflow_o = ovf;
  assign inexact_o  = (|mant_i[2:0]) | ovf;
`endif

endmodule

// File: rtl/fpu_adder.sv
// Multi-cycle IEEE-754 binary32 adder (RNE) with strobe/ack handshakes.
// Define FPU_ADDER_FLAGS_EN to add output_flags = {invalid, overflow, inexact}.
module fpu_adder
  import fpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_a,
  input  logic        input_a_stb,
  output logic        input_a_ack,
  input  logic [31:0] input_b,
  input  logic        input_b_stb,
  output logic        input_b_ack,
  output logic [31:0] output_z,
  output logic        output_z_stb,
  input  logic        output_z_ack
`ifdef FPU_ADDER_FLAGS_EN
  ,
  output logic [2:0]  output_flags
`endif
);

  state_t      state_q, state_d;
  logic [31:0] a_raw_q, a_raw_d, b_raw_q, b_raw_d;
  operand_t    a_q, a_d, b_q, b_d, z_q, z_d;
  logic [31:0] res_q, res_d, z_out_q, z_out_d;
  logic        a_ack_q, a_ack_d, b_ack_q, b_ack_d, z_stb_q, z_stb_d;

  logic [31:0]       rp_z;
  logic [27:0]       sum;
  logic signed [9:0] exp_diff;
  logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

`ifdef FPU_ADDER_FLAGS_EN
  logic [2:0] flags_q, flags_d;
  logic       rp_ovf, rp_inexact;
`endif

  fpu_round_pack u_round_pack (
    .sign_i     (z_q.sign),
    .exp_i      (z_q.exp),
    .mant_i     (z_q.mant),
    .z_o        (rp_z)
`ifdef FPU_ADDER_FLAGS_EN
    ,
    .overflow_o (rp_ovf),
    .inexact_o  (rp_inexact)
`endif
  );

  assign a_inf  = (a_raw_q[30:23] == 8'hFF) && (a_raw_q[22:0] == 23'd0);
  assign b_inf  = (b_raw_q[30:23] == 8'hFF) && (b_raw_q[22:0] == 23'd0);
  assign a_nan  = (a_raw_q[30:23] == 8'hFF) && (a_raw_q[22:0] != 23'd0);
  assign b_nan  = (b_raw_q[30:23] == 8'hFF) && (b_raw_q[22:0] != 23'd0);
  assign a_zero = (a_raw_q[30:0] == 31'd0);
  assign b_zero = (b_raw_q[30:0] == 31'd0);

  always_comb begin
    state_d  = state_q;
    a_raw_d  = a_raw_q;
    b_raw_d  = b_raw_q;
    a_d      = a_q;
    b_d      = b_q;
    z_d      = z_q;
    res_d    = res_q;
    z_out_d  = z_out_q;
    a_ack_d  = a_ack_q;
    b_ack_d  = b_ack_q;
    z_stb_d  = z_stb_q;
    sum      = '0;
    exp_diff = a_q.exp - b_q.exp;
`ifdef FPU_ADDER_FLAGS_EN
    flags_d  = flags_q;
`endif
    case (state_q)
      GET_A: begin
        a_ack_d = 1'b1;
        if (input_a_stb && a_ack_q) begin
          a_raw_d = input_a;
          a_ack_d = 1'b0;
          state_d = GET_B;
`ifdef FPU_ADDER_FLAGS_EN
          flags_d = '0;
`endif
        end
      end
      GET_B: begin
        b_ack_d = 1'b1;
        if (input_b_stb && b_ack_q) begin
          b_raw_d = input_b;
          b_ack_d = 1'b0;
          state_d = UNPACK;
        end
      end
      UNPACK: begin
        a_d     = unpack_operand(a_raw_q);
        b_d     = unpack_operand(b_raw_q);
        state_d = SPECIAL;
      end
      SPECIAL: begin
        // Special results bypass the datapath; stb rises together with PUT_Z.
        state_d = PUT_Z;
        z_stb_d = 1'b1;
        if (a_nan || b_nan || (a_inf && b_inf && (a_raw_q[31] != b_raw_q[31]))) begin
          z_out_d = QNAN;
`ifdef FPU_ADDER_FLAGS_EN
          flags_d[2] = 1'b1;
`endif
        end else if (a_inf) begin
          z_out_d = a_raw_q;
        end else if (b_inf) begin
          z_out_d = b_raw_q;
        end else if (a_zero && b_zero) begin
          z_out_d = {a_raw_q[31] & b_raw_q[31], 31'd0};
        end else if (a_zero) begin
          z_out_d = b_raw_q;
        end else if (b_zero) begin
          z_out_d = a_raw_q;
        end else begin
          state_d = ALIGN;
          z_stb_d = 1'b0;
        end
      end
      ALIGN: begin
        if (exp_diff > 10'sd26) begin
          b_d.mant = {26'd0, |b_q.mant};
          b_d.exp  = a_q.exp;
        end else if (exp_diff < -10'sd26) begin
          a_d.mant = {26'd0, |a_q.mant};
          a_d.exp  = b_q.exp;
        end else if (exp_diff > 10'sd0) begin
          b_d.mant = {1'b0, b_q.mant[26:2], b_q.mant[1] | b_q.mant[0]};
          b_d.exp  = b_q.exp + 10'sd1;
        end else if (exp_diff < 10'sd0) begin
          a_d.mant = {1'b0, a_q.mant[26:2], a_q.mant[1] | a_q.mant[0]};
          a_d.exp  = a_q.exp + 10'sd1;
        end else begin
          state_d = ADD;
        end
      end
      ADD: begin
        z_d.exp = a_q.exp;
        if (a_q.sign == b_q.sign) begin
          sum        = {1'b0, a_q.mant} + {1'b0, b_q.mant};
          z_d.sign   = a_q.sign;
        end else if (a_q.mant >= b_q.mant) begin
          sum        = {1'b0, a_q.mant} - {1'b0, b_q.mant};
          z_d.sign   = a_q.sign;
        end else begin
          sum        = {1'b0, b_q.mant} - {1'b0, a_q.mant};
          z_d.sign   = b_q.sign;
        end
        if (sum == '0) begin
          z_d.sign = 1'b0;
          z_d.exp  = EXP_MIN;
          z_d.mant = '0;
        end else if (sum[27]) begin
          z_d.mant = {sum[27:2], sum[1] | sum[0]};
          z_d.exp  = a_q.exp + 10'sd1;
        end else begin
          z_d.mant = sum[26:0];
        end
        state_d = NORM;
      end
      NORM: begin
        if (z_q.exp < EXP_MIN) begin
          z_d.mant = {1'b0, z_q.mant[26:2], z_q.mant[1] | z_q.mant[0]};
          z_d.exp  = z_q.exp + 10'sd1;
        end else if (!z_q.mant[26] && (z_q.exp > EXP_MIN)) begin
          // Sticky stays in place; guard moves into the LSB, round into guard.
          z_d.mant = {z_q.mant[25:1], 1'b0, z_q.mant[0]};
          z_d.exp  = z_q.exp - 10'sd1;
        end else begin
          state_d = ROUND;
        end
      end
      ROUND: begin
        res_d   = rp_z;
        state_d = PACK;
`ifdef FPU_ADDER_FLAGS_EN
        flags_d[1] = flags_q[1] | rp_ovf;
        flags_d[0] = flags_q[0] | rp_inexact;
`endif
      end
      PACK: begin
        z_out_d = res_q;
        z_stb_d = 1'b1;
        state_d = PUT_Z;
      end
      PUT_Z: begin
        if (z_stb_q && output_z_ack) begin
          z_stb_d = 1'b0;
          state_d = GET_A;
        end
      end
      default: state_d = GET_A;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= GET_A;
      a_raw_q <= '0;
      b_raw_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      z_q     <= '0;
      res_q   <= '0;
      z_out_q <= '0;
      a_ack_q <= 1'b0;
      b_ack_q <= 1'b0;
      z_stb_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_raw_q <= a_raw_d;
      b_raw_q <= b_raw_d;
      a_q     <= a_d;
      b_q     <= b_d;
      z_q     <= z_d;
      res_q   <= res_d;
      z_out_q <= z_out_d;
      a_ack_q <= a_ack_d;
      b_ack_q <= b_ack_d;
      z_stb_q <= z_stb_d;
    end
  end

`ifdef FPU_ADDER_FLAGS_EN
  always_ff @(posedge clk) begin
    if (!rst) flags_q <= '0;
    else      flags_q <= flags_d;
  end
  assign output_flags = flags_q;
`endif

  assign input_a_ack  = a_ack_q;
  assign input_b_ack  = b_ack_q;
  assign output_z     = z_out_q;
  assign output_z_stb = z_stb_q;

endmodule

// File: tb/tb_fpu_adder.sv
// Self-checking bench for fpu_adder: directed vectors, handshake/reset scenarios
// and randomized operands against an exact-arithmetic binary32 reference.
module tb_fpu_adder;
  import fpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] input_a, input_b;
  logic        input_a_stb, input_b_stb;
  logic        input_a_ack, input_b_ack;
  logic [31:0] output_z;
  logic        output_z_stb, output_z_ack;
`ifdef FPU_ADDER_FLAGS_EN
  logic [2:0]  output_flags;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fpu_adder dut (
    .clk          (clk),
    .rst          (rst),
    .input_a      (input_a),
    .input_a_stb  (input_a_stb),
    .input_a_ack  (input_a_ack),
    .input_b      (input_b),
    .input_b_stb  (input_b_stb),
    .input_b_ack  (input_b_ack),
    .output_z     (output_z),
    .output_z_stb (output_z_stb),
    .output_z_ack (output_z_ack)
`ifdef FPU_ADDER_FLAGS_EN
    ,
    .output_flags (output_flags)
`endif
  );

  // Exact magnitude in units of 2^-149.
  function automatic logic [299:0] mag(input logic [31:0] f);
    logic [299:0] m;
    m = '0;
    if (f[30:23] == 8'd0) begin
      m[22:0] = f[22:0];
    end else begin
      m[23:0] = {1'b1, f[22:0]};
      m = m << (int'(f[30:23]) - 1);
    end
    return m;
  endfunction

  task automatic model_add(input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] z, output logic [2:0] fl);
    logic [299:0] ma, mb, s, q, rem, half, one;
    logic         sg, up;
    logic         a_nan, b_nan, a_inf, b_inf;
    int           p, sh, ef;
    one   = 300'd1;
    fl    = 3'b000;
    a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    a_inf = (a[30:23] == 8'hFF) && (a[22:0] == 0);
    b_inf = (b[30:23] == 8'hFF) && (b[22:0] == 0);
    if (a_nan || b_nan || (a_inf && b_inf && a[31] != b[31])) begin
      z = 32'h7FC00000; fl = 3'b100; return;
    end
    if (a_inf) begin z = a; return; end
    if (b_inf) begin z = b; return; end
    if (a[30:0] == 0 && b[30:0] == 0) begin z = {a[31] & b[31], 31'd0}; return; end
    ma = mag(a); mb = mag(b);
    if (a[31] == b[31])  begin s = ma + mb; sg = a[31]; end
    else if (ma >= mb)   begin s = ma - mb; sg = a[31]; end
    else                 begin s = mb - ma; sg = b[31]; end
    if (s == 0) begin z = 32'd0; return; end
    p = 0;
    for (int i = 0; i < 300; i++) if (s[i]) p = i;
    if (p < 24) begin z = {sg, 7'd0, s[23:0]}; return; end
    sh   = p - 23;
    q    = s >> sh;
    rem  = s & ((one << sh) - one);
    half = one << (sh - 1);
    up   = (rem > half) || (rem == half && q[0]);
    q    = q + {299'd0, up};
    if (q[24]) begin q = q >> 1; sh = sh + 1; end
    ef = sh + 1;
    if (ef >= 255) begin
      z = {sg, 8'hFF, 23'd0}; fl = 3'b011;
    end else begin
      z = {sg, 8'(ef), q[22:0]}; fl = {2'b00, rem != 0};
    end
  endtask

  task automatic send_a(input logic [31:0] v, input bit keep, output bit ok);
    int n = 0;
    ok = 1'b1;
    input_a = v; input_a_stb = 1'b1;
    while (!input_a_ack) begin
      @(posedge clk); #1; n++;
      if (n > 200) begin
        checks++; errors++; ok = 1'b0;
        $display("FAIL a_accept_timeout: input_a_ack got 0 required 1");
        input_a_stb = 1'b0; return;
      end
    end
    @(posedge clk); #1;
    if (!keep) input_a_stb = 1'b0;
  endtask

  task automatic send_b(input logic [31:0] v, output bit ok);
    int n = 0;
    ok = 1'b1;
    input_b = v; input_b_stb = 1'b1;
    while (!input_b_ack) begin
      @(posedge clk); #1; n++;
      if (n > 200) begin
        checks++; errors++; ok = 1'b0;
        $display("FAIL b_accept_timeout: input_b_ack got 0 required 1");
        input_b_stb = 1'b0; return;
      end
    end
    @(posedge clk); #1;
    input_b_stb = 1'b0;
  endtask

  task automatic wait_z(output bit ok);
    int n = 0;
    ok = 1'b1;
    while (!output_z_stb) begin
      @(posedge clk); #1; n++;
      if (n > 200) begin
        checks++; errors++; ok = 1'b0;
        $display("FAIL z_timeout: output_z_stb got 0 required 1");
        return;
      end
    end
  endtask

  task automatic get_z(output logic [31:0] z, output logic [2:0] fl, output bit ok);
    wait_z(ok);
    z  = output_z;
    fl = 3'b000;
`ifdef FPU_ADDER_FLAGS_EN
    fl = output_flags;
`endif
    output_z_ack = 1'b1;
    @(posedge clk); #1;
    output_z_ack = 1'b0;
  endtask

  task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] z, output logic [2:0] fl, output bit ok);
    bit ok1, ok2;
    send_a(a, 1'b0, ok1);
    send_b(b, ok2);
    z = '0; fl = '0; ok = 1'b0;
    if (ok1 && ok2) get_z(z, fl, ok);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    checks++; if (input_a_ack !== 1'b0) begin errors++; $display("FAIL reset_a_ack: got %b required 0", input_a_ack); end
    checks++; if (input_b_ack !== 1'b0) begin errors++; $display("FAIL reset_b_ack: got %b required 0", input_b_ack); end
    checks++; if (output_z_stb !== 1'b0) begin errors++; $display("FAIL reset_z_stb: got %b required 0", output_z_stb); end
    checks++; if (output_z !== 32'd0) begin errors++; $display("FAIL reset_z: got %h required 00000000", output_z); end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (input_a_ack !== 1'b1) begin errors++; $display("FAIL release_a_ack: got %b required 1", input_a_ack); end
  endtask

  task automatic test_vectors();
    logic [31:0] va [9] = '{32'h40866666, 32'h42306666, 32'h7F800000, 32'h3F800000,
                            32'h7F7FFFFF, 32'h00000001, 32'h4B800000, 32'h3F800000, 32'h80000000};
    logic [31:0] vb [9] = '{32'h41280000, 32'h3F800000, 32'hFF800000, 32'hBF800000,
                            32'h7F7FFFFF, 32'h00000001, 32'h3F800000, 32'h40000000, 32'h80000000};
    logic [31:0] vz [9] = '{32'h416B3333, 32'h42346666, 32'h7FC00000, 32'h00000000,
                            32'h7F800000, 32'h00000002, 32'h4B800000, 32'h40400000, 32'h80000000};
    logic [2:0]  vf [9] = '{3'b000, 3'b000, 3'b100, 3'b000, 3'b011, 3'b000, 3'b001, 3'b000, 3'b000};
    logic [31:0] z;
    logic [2:0]  fl;
    bit ok;
    for (int i = 0; i < 9; i++) begin
      do_op(va[i], vb[i], z, fl, ok);
      if (ok) begin
        checks++;
        if (z !== vz[i]) begin errors++; $display("FAIL vector%0d_z: %h+%h got %h required %h", i, va[i], vb[i], z, vz[i]); end
`ifdef FPU_ADDER_FLAGS_EN
        checks++;
        if (fl !== vf[i]) begin errors++; $display("FAIL vector%0d_flags: got %b required %b", i, fl, vf[i]); end
`endif
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, z, ez;
    logic [2:0]  fl, ef;
    bit ok;
    int sel, e;
    for (int i = 0; i < 300; i++) begin
      sel = $urandom_range(0, 9);
      a = {1'($urandom_range(0, 1)), 8'($urandom_range(1, 254)), 23'($urandom)};
      case (sel)
        0, 1: begin a = $urandom; b = $urandom; end
        7:    b = a ^ 32'h80000000;
        8:    begin a[30:23] = 8'd0; b = {1'($urandom_range(0, 1)), 8'($urandom_range(0, 1)), 23'($urandom)}; end
        9:    b = (i % 3 == 0) ? 32'h7F800000 : (i % 3 == 1) ? 32'h80000000 : 32'h7FA00001;
        default: begin
          e = int'(a[30:23]) + $urandom_range(0, 60) - 30;
          if (e < 0) e = 0;
          if (e > 254) e = 254;
          b = {1'($urandom_range(0, 1)), 8'(e), 23'($urandom)};
        end
      endcase
      model_add(a, b, ez, ef);
      do_op(a, b, z, fl, ok);
      if (!ok) return;
      checks++;
      if (z !== ez) begin errors++; $display("FAIL random_z: %h+%h got %h required %h", a, b, z, ez); end
`ifdef FPU_ADDER_FLAGS_EN
      checks++;
      if (fl !== ef) begin errors++; $display("FAIL random_flags: %h+%h got %b required %b", a, b, fl, ef); end
`endif
    end
  endtask

  task automatic test_hold_ack();
    logic [31:0] z0, ez;
    logic [2:0]  ef;
    bit ok1, ok2, ok;
    model_add(32'h40866666, 32'hC1280000, ez, ef);
    send_a(32'h40866666, 1'b0, ok1);
    send_b(32'hC1280000, ok2);
    if (!(ok1 && ok2)) return;
    wait_z(ok);
    if (!ok) return;
    z0 = output_z;
    checks++;
    if (z0 !== ez) begin errors++; $display("FAIL hold_result: got %h required %h", z0, ez); end
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      checks++;
      if (output_z_stb !== 1'b1 || output_z !== z0) begin
        errors++; $display("FAIL hold_stable: cycle %0d stb=%b z=%h required stb=1 z=%h", c, output_z_stb, output_z, z0);
      end
    end
    output_z_ack = 1'b1;
    @(posedge clk); #1;
    output_z_ack = 1'b0;
    checks++;
    if (output_z_stb !== 1'b0) begin errors++; $display("FAIL hold_release: stb got %b required 0", output_z_stb); end
  endtask

  task automatic test_b_first();
    logic [31:0] z, ez;
    logic [2:0]  fl, ef;
    bit ok1, ok2, ok, early;
    early = 1'b0;
    input_b = 32'h3FC00000; input_b_stb = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (input_b_ack !== 1'b0) early = 1'b1;
    end
    checks++;
    if (early) begin errors++; $display("FAIL b_before_a: input_b_ack got 1 required 0"); end
    model_add(32'h40200000, 32'h3FC00000, ez, ef);
    send_a(32'h40200000, 1'b0, ok1);
    send_b(32'h3FC00000, ok2);
    if (!(ok1 && ok2)) return;
    get_z(z, fl, ok);
    if (!ok) return;
    checks++;
    if (z !== ez) begin errors++; $display("FAIL b_first_result: got %h required %h", z, ez); end
  endtask

  // Product stream held on port A; the held strobe must not re-accept until GET_A.
  task automatic test_back_to_back();
    logic [31:0] pa [2] = '{32'h42306666, 32'hC0490FDB};
    logic [31:0] pb [2] = '{32'h3F800000, 32'h40C00000};
    logic [31:0] z, ez;
    logic [2:0]  fl, ef;
    bit ok1, ok2, ok;
    for (int i = 0; i < 2; i++) begin
      model_add(pa[i], pb[i], ez, ef);
      send_a(pa[i], (i == 0), ok1);
      send_b(pb[i], ok2);
      if (!(ok1 && ok2)) return;
      get_z(z, fl, ok);
      if (!ok) return;
      checks++;
      if (z !== ez) begin errors++; $display("FAIL back_to_back%0d: got %h required %h", i, z, ez); end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] z;
    logic [2:0]  fl;
    bit ok1, ok2, ok;
    send_a(32'h4B800000, 1'b0, ok1);
    send_b(32'h3F800000, ok2);
    if (!(ok1 && ok2)) return;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (dut.state_q !== ALIGN) begin errors++; $display("FAIL mid_in_align: state got %0d required %0d", dut.state_q, ALIGN); end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (output_z_stb !== 1'b0 || dut.state_q !== GET_A) begin
      errors++; $display("FAIL mid_reset: stb=%b state=%0d required stb=0 state=%0d", output_z_stb, dut.state_q, GET_A);
    end
    rst = 1'b1;
    do_op(32'h3F800000, 32'h40000000, z, fl, ok);
    if (!ok) return;
    checks++;
    if (z !== 32'h40400000) begin errors++; $display("FAIL after_mid_reset: got %h required 40400000", z); end
  endtask

  initial begin
    rst = 1'b0; input_a = '0; input_b = '0;
    input_a_stb = 1'b0; input_b_stb = 1'b0; output_z_ack = 1'b0;
    test_reset();
    test_vectors();
    test_hold_ack();
    test_b_first();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
